// File: rtl/systolic_output_deskew.sv
// Output deskew for the weight-stationary systolic array.
// Gathers the diagonally skewed per-lane column stream into an N x N matrix,
// holds it, and hands it downstream over a valid/ready handshake.
module systolic_output_deskew #(
    parameter int unsigned N   = 4,
    parameter int unsigned LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  real  col_in     [0:N-1],
    output real  result_out [0:N-1][0:N-1],
    output logic result_valid,
    input  logic result_ready,
    output logic busy,
    output logic start_dropped
);

    // Counter value at which the final sample (row N-1 on lane N-1) arrives.
    localparam int unsigned LAST = LAT + 2 * N - 2;
    localparam int unsigned CW   = $clog2(LAT + 2 * N);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          valid_next;
    logic          dropped_next;

    // Next-state, counter and handshake decisions.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        valid_next   = result_valid;
        dropped_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = COLLECT;
                    cnt_next   = '0;
                end
            end
            COLLECT: begin
                if (start) begin
                    dropped_next = 1'b1;
                end
                if (32'(cnt) == LAST) begin
                    state_next = HOLD;
                    valid_next = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (result_ready) begin
                    valid_next = 1'b0;
                    if (start) begin
                        state_next = COLLECT;
                        cnt_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (start) begin
                    dropped_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    // Control registers: state, pass counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            result_valid  <= 1'b0;
            busy          <= 1'b0;
            start_dropped <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            result_valid  <= valid_next;
            busy          <= (state_next != IDLE);
            start_dropped <= dropped_next;
        end
    end

    // Capture: lane j carries row r while the counter equals LAT + r + j.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < N; r++) begin
                for (int unsigned j = 0; j < N; j++) begin
                    result_out[r][j] <= 0.0;
                end
            end
        end else if (state == COLLECT) begin
            for (int unsigned r = 0; r < N; r++) begin
                for (int unsigned j = 0; j < N; j++) begin
                    if (32'(cnt) == r + j + LAT) begin
                        result_out[r][j] <= col_in[j];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Self-checking bench for systolic_output_deskew: main N=4/LAT=2 instance plus
// N=1/LAT=0 and N=8/LAT=15 corner instances, checked against a matrix model.
module tb_systolic_output_deskew;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   checks   = 0;
    int   failures = 0;
    real  nan;

    // Main instance N=4, LAT=2
    logic s4, rdy4, v4, b4, d4;
    real  col4 [0:3];
    real  res4 [0:3][0:3];
    real  m4   [0:3][0:3];
    real  held4[0:3][0:3];

    // Corner instance N=1, LAT=0
    logic s1, rdy1, v1, b1, d1;
    real  col1 [0:0];
    real  res1 [0:0][0:0];

    // Corner instance N=8, LAT=15
    logic s8, rdy8, v8, b8, d8;
    real  col8 [0:7];
    real  res8 [0:7][0:7];
    real  m8   [0:7][0:7];

    systolic_output_deskew #(.N(4), .LAT(2)) dut4 (
        .clk(clk), .reset(reset), .start(s4), .col_in(col4), .result_out(res4),
        .result_valid(v4), .result_ready(rdy4), .busy(b4), .start_dropped(d4)
    );

    systolic_output_deskew #(.N(1), .LAT(0)) dut1 (
        .clk(clk), .reset(reset), .start(s1), .col_in(col1), .result_out(res1),
        .result_valid(v1), .result_ready(rdy1), .busy(b1), .start_dropped(d1)
    );

    systolic_output_deskew #(.N(8), .LAT(15)) dut8 (
        .clk(clk), .reset(reset), .start(s8), .col_in(col8), .result_out(res8),
        .result_valid(v8), .result_ready(rdy8), .busy(b8), .start_dropped(d8)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkr(input string tag, input real obs, input real exp);
        logic [63:0] ob;
        logic [63:0] ex;
        ob = $realtobits(obs);
        ex = $realtobits(exp);
        checks++;
        assert (ob === ex) else begin
            failures++;
            $error("FAIL %s: observed %g (%h) expected %g (%h)", tag, obs, ob, exp, ex);
        end
    endtask

    function automatic real rnd_real();
        return real'($urandom_range(0, 1000000)) / 8.0 - 60000.0;
    endfunction

    task automatic chk_mat4(input string tag);
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++)
                chkr($sformatf("%s[%0d][%0d]", tag, r, j), res4[r][j], held4[r][j]);
    endtask

    // base < 0 selects random contents, otherwise base + 10*r + j
    task automatic fill4(input int base);
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++)
                m4[r][j] = (base < 0) ? rnd_real() : real'(base + 10 * r + j);
    endtask

    task automatic latch4;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++)
                held4[r][j] = m4[r][j];
    endtask

    // Lane j presents row (c - LAT - j) while the pass counter is c.
    task automatic drive4(input int c);
        for (int j = 0; j < 4; j++) begin
            int r;
            r = c - 2 - j;
            col4[j] = (r >= 0 && r < 4) ? m4[r][j] : nan;
        end
    endtask

    task automatic start4;
        s4 = 1'b1;
        tick;
        s4 = 1'b0;
        chk1("start_busy", b4, 1'b1);
        chk1("start_valid", v4, 1'b0);
    endtask

    // Walk counter values 0..last_c; valid must rise only after c = 8.
    task automatic collect4(input int drop_at, input int last_c);
        for (int c = 0; c <= last_c; c++) begin
            drive4(c);
            s4 = (c == drop_at);
            tick;
            s4 = 1'b0;
            chk1($sformatf("collect_busy c=%0d", c), b4, 1'b1);
            chk1($sformatf("collect_drop c=%0d", c), d4, c == drop_at);
            chk1($sformatf("collect_valid c=%0d", c), v4, c == 8);
        end
        for (int j = 0; j < 4; j++) col4[j] = nan;
    endtask

    initial begin
        nan = $bitstoreal(64'h7FF8_0000_0000_0000);
        reset = 1'b1;
        s4 = 1'b0; rdy4 = 1'b1;
        s1 = 1'b0; rdy1 = 1'b1;
        s8 = 1'b0; rdy8 = 1'b1;
        for (int j = 0; j < 4; j++) col4[j] = nan;
        col1[0] = nan;
        for (int j = 0; j < 8; j++) col8[j] = nan;
        tick;
        tick;

        // Reset state
        chk1("rst_valid", v4, 1'b0);
        chk1("rst_busy", b4, 1'b0);
        chk1("rst_drop", d4, 1'b0);
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++)
                held4[r][j] = 0.0;
        chk_mat4("rst_mat");
        chk1("rst_valid_n1", v1, 1'b0);
        chk1("rst_valid_n8", v8, 1'b0);
        reset = 1'b0;
        tick;

        // Basic pass, ready tied high, data 10*r + j
        rdy4 = 1'b1;
        fill4(0);
        start4;
        collect4(-1, 8);
        latch4;
        chk_mat4("basic");
        tick;
        chk1("basic_valid_one_cycle", v4, 1'b0);
        chk1("basic_idle", b4, 1'b0);
        chk_mat4("basic_kept");
        tick;
        chk1("basic_still_idle", b4, 1'b0);

        // Back-pressure with a dropped start in COLLECT and in stalled HOLD
        rdy4 = 1'b0;
        fill4(-1);
        start4;
        collect4(3, 8);
        latch4;
        for (int k = 0; k < 20; k++) begin
            s4 = (k == 10);
            tick;
            s4 = 1'b0;
            chk1($sformatf("stall_valid k=%0d", k), v4, 1'b1);
            chk1($sformatf("stall_busy k=%0d", k), b4, 1'b1);
            chk1($sformatf("stall_drop k=%0d", k), d4, k == 10);
            chk_mat4($sformatf("stall_mat k=%0d", k));
        end
        rdy4 = 1'b1;
        tick;
        chk1("stall_release_valid", v4, 1'b0);
        chk1("stall_release_busy", b4, 1'b0);
        rdy4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk1("no_extra_pass_busy", b4, 1'b0);
            chk1("no_extra_pass_valid", v4, 1'b0);
        end

        // Back-to-back passes: start on the handshake edge
        fill4(0);
        start4;
        collect4(-1, 8);
        latch4;
        chk_mat4("b2b_first");
        tick;
        chk1("b2b_hold_valid", v4, 1'b1);
        fill4(100);
        rdy4 = 1'b1;
        s4 = 1'b1;
        tick;
        s4 = 1'b0;
        rdy4 = 1'b0;
        chk1("b2b_valid_cleared", v4, 1'b0);
        chk1("b2b_no_idle", b4, 1'b1);
        chk1("b2b_no_drop", d4, 1'b0);
        chk_mat4("b2b_first_intact");
        collect4(-1, 8);
        latch4;
        chk_mat4("b2b_second");
        rdy4 = 1'b1;
        tick;
        chk1("b2b_done_valid", v4, 1'b0);
        chk1("b2b_done_busy", b4, 1'b0);

        // Reset at c = 5
        fill4(-1);
        start4;
        collect4(-1, 4);
        drive4(5);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        for (int j = 0; j < 4; j++) col4[j] = nan;
        chk1("midrst_valid", v4, 1'b0);
        chk1("midrst_busy", b4, 1'b0);
        chk1("midrst_drop", d4, 1'b0);
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++)
                held4[r][j] = 0.0;
        chk_mat4("midrst_mat");
        tick;
        chk1("midrst_stays_idle", b4, 1'b0);
        fill4(-1);
        start4;
        collect4(-1, 8);
        latch4;
        chk_mat4("postrst");
        tick;
        chk1("postrst_valid", v4, 1'b0);

        // Random passes with random stall lengths
        for (int p = 0; p < 4; p++) begin
            int stall;
            stall = int'($urandom_range(0, 6));
            rdy4 = 1'b0;
            fill4(-1);
            start4;
            collect4(-1, 8);
            latch4;
            chk_mat4($sformatf("rand%0d", p));
            for (int k = 0; k < stall; k++) begin
                tick;
                chk1("rand_stall_valid", v4, 1'b1);
            end
            rdy4 = 1'b1;
            tick;
            chk1("rand_done_valid", v4, 1'b0);
            chk1("rand_done_busy", b4, 1'b0);
            chk_mat4($sformatf("rand%0d_kept", p));
        end

        // Corner N=1, LAT=0: valid one edge after the start edge
        for (int p = 0; p < 3; p++) begin
            real v;
            v = rnd_real();
            s1 = 1'b1;
            tick;
            s1 = 1'b0;
            chk1("n1_busy", b1, 1'b1);
            chk1("n1_valid_early", v1, 1'b0);
            col1[0] = v;
            tick;
            col1[0] = nan;
            chk1("n1_valid", v1, 1'b1);
            chkr("n1_data", res1[0][0], v);
            tick;
            chk1("n1_valid_clear", v1, 1'b0);
            chk1("n1_idle", b1, 1'b0);
            chk1("n1_drop", d1, 1'b0);
        end

        // Corner N=8, LAT=15: valid 30 edges after the start edge
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 8; j++)
                m8[r][j] = rnd_real();
        s8 = 1'b1;
        tick;
        s8 = 1'b0;
        chk1("n8_busy", b8, 1'b1);
        for (int c = 0; c <= 29; c++) begin
            for (int j = 0; j < 8; j++) begin
                int r;
                r = c - 15 - j;
                col8[j] = (r >= 0 && r < 8) ? m8[r][j] : nan;
            end
            tick;
            chk1($sformatf("n8_valid c=%0d", c), v8, c == 29);
        end
        for (int j = 0; j < 8; j++) col8[j] = nan;
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 8; j++)
                chkr($sformatf("n8[%0d][%0d]", r, j), res8[r][j], m8[r][j]);
        tick;
        chk1("n8_valid_clear", v8, 1'b0);
        chk1("n8_idle", b8, 1'b0);
        chk1("n8_drop", d8, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
